// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Shares the single write port of the 32 x 32-bit register file among three
//   writeback requesters (0 = ALU, 1 = load unit, 2 = mul/div). One requester
//   is granted per cycle in round-robin order starting at the priority pointer.
//   The granted write is registered onto the rf_* port. A per-register pending
//   scoreboard lets the issue stage stall on read-after-write hazards.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  per-requester write request
//   req_ready  per-requester grant (combinational, at most one bit high)
//   req_addr   destination index, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   write data, requester i at [i*DATA_W +: DATA_W]
//   rsv_valid  issue stage reserves rsv_addr
//   rsv_addr   register being reserved
//   rf_we      register-file write enable (registered)
//   rf_waddr   register-file write index (registered)
//   rf_wdata   register-file write data (registered)
//   pending    bit r set while a write to register r is outstanding
module rf_writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [31:0]              pending
);

    logic [1:0]        r_ptr;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [31:0]       r_pending;

    logic              w_xfer;
    logic [1:0]        w_gidx;
    logic [1:0]        w_ptr_next;
    logic [NREQ-1:0]   w_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_write;
    logic [31:0]       w_pending_next;

    // Scan order starts at r_ptr and wraps modulo 3.
    always_comb begin
        w_xfer = 1'b0;
        w_gidx = 2'd0;
        case (r_ptr)
            2'd1: begin
                if (req_valid[1])      begin w_xfer = 1'b1; w_gidx = 2'd1; end
                else if (req_valid[2]) begin w_xfer = 1'b1; w_gidx = 2'd2; end
                else if (req_valid[0]) begin w_xfer = 1'b1; w_gidx = 2'd0; end
            end
            2'd2: begin
                if (req_valid[2])      begin w_xfer = 1'b1; w_gidx = 2'd2; end
                else if (req_valid[0]) begin w_xfer = 1'b1; w_gidx = 2'd0; end
                else if (req_valid[1]) begin w_xfer = 1'b1; w_gidx = 2'd1; end
            end
            default: begin
                if (req_valid[0])      begin w_xfer = 1'b1; w_gidx = 2'd0; end
                else if (req_valid[1]) begin w_xfer = 1'b1; w_gidx = 2'd1; end
                else if (req_valid[2]) begin w_xfer = 1'b1; w_gidx = 2'd2; end
            end
        endcase
    end

    always_comb begin
        w_grant = '0;
        if (w_xfer) begin
            w_grant = NREQ'(1) << w_gidx;
        end
    end

    // Grants are suppressed during reset so no requester believes it
    // transferred into a write the reset is about to discard.
    assign req_ready  = rst ? '0 : w_grant;
    assign w_ptr_next = (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;

    always_comb begin
        case (w_gidx)
            2'd1: begin
                w_sel_addr = req_addr[ADDR_W +: ADDR_W];
                w_sel_data = req_data[DATA_W +: DATA_W];
            end
            2'd2: begin
                w_sel_addr = req_addr[2*ADDR_W +: ADDR_W];
                w_sel_data = req_data[2*DATA_W +: DATA_W];
            end
            default: begin
                w_sel_addr = req_addr[0 +: ADDR_W];
                w_sel_data = req_data[0 +: DATA_W];
            end
        endcase
    end

    // Writes to register 0 are accepted but never reach the register file.
    assign w_write = w_xfer && (w_sel_addr != '0);

    // Set after clear so a new reservation on the commit edge wins.
    always_comb begin
        w_pending_next = r_pending;
        if (r_rf_we) begin
            w_pending_next[r_rf_waddr] = 1'b0;
        end
        if (rsv_valid) begin
            w_pending_next[rsv_addr] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= 2'd0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_pending  <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr <= w_ptr_next;
            end
            r_rf_we <= w_write;
            if (w_write) begin
                r_rf_waddr <= w_sel_addr;
                r_rf_wdata <= w_sel_data;
            end
            r_pending <= w_pending_next;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign pending  = r_pending;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter
//   Directed bench for rf_writeback_arbiter. A small reference model tracks
//   the priority pointer and the pending scoreboard; granted writes are pushed
//   to a queue and popped when the DUT raises rf_we.
module tb_rf_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    logic [4:0]  a [3];
    logic [31:0] d [3];

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .NREQ(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;

    int          m_ptr;
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [4:0]  m_haddr;
    logic [31:0] m_hdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int grant_of(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    // Inputs are set by the caller just after a rising edge; this checks the
    // combinational grant, advances the model across one edge, then checks
    // the registered outputs.
    task automatic cycle();
        int          g;
        logic [2:0]  er;
        logic        nwe;
        logic [4:0]  ga;
        logic [31:0] gd;
        logic [31:0] pn;
        wr_t         e;
        #1;
        g  = grant_of(req_valid, m_ptr);
        er = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("req_ready", 32'(req_ready), 32'(er));
        nwe = 1'b0;
        ga  = '0;
        gd  = '0;
        if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            ga = a[g];
            gd = d[g];
            if (ga != 5'd0) begin
                sb.push_back({ga, gd});
                nwe = 1'b1;
            end
        end
        pn = m_pend;
        if (m_we) pn[m_waddr] = 1'b0;
        if (rsv_valid && rsv_addr != 5'd0) pn[rsv_addr] = 1'b1;
        @(posedge clk);
        #1;
        m_pend = pn;
        m_we   = nwe;
        if (nwe) begin
            m_waddr = ga;
            m_haddr = ga;
            m_hdata = gd;
        end
        chk("rf_we", 32'(rf_we), 32'(m_we));
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(0), 32'(1));
            end else begin
                e = sb.pop_front();
                chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
                chk("rf_wdata", rf_wdata, e.data);
            end
        end else begin
            chk("rf_waddr_hold", 32'(rf_waddr), 32'(m_haddr));
            chk("rf_wdata_hold", rf_wdata, m_hdata);
        end
        chk("pending", pending, m_pend);
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_pend  = '0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_haddr = '0;
        m_hdata = '0;
        sb.delete();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b111;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        model_reset();

        // Power-on reset
        #2;
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_we", 32'(rf_we), 32'(0));
        chk("rst_waddr", 32'(rf_waddr), 32'(0));
        chk("rst_wdata", rf_wdata, 32'(0));
        chk("rst_pending", pending, 32'(0));
        req_valid = 3'b000;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Build up rf_we=1 with pending=0x10, then reset mid-cycle
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        cycle();
        rsv_valid = 1'b0;
        chk("pend_0x10", pending, 32'h0000_0010);
        req_valid = 3'b001; a[0] = 5'd9; d[0] = 32'h0000_0099;
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("async_we", 32'(rf_we), 32'(0));
        chk("async_waddr", 32'(rf_waddr), 32'(0));
        chk("async_wdata", rf_wdata, 32'(0));
        chk("async_pending", pending, 32'(0));
        chk("async_ready", 32'(req_ready), 32'(0));
        model_reset();
        #2 rst = 1'b0;
        a[0] = 5'd1; d[0] = 32'h0000_0011;
        cycle();

        // Backpressure with ptr=1: requester 1 first, requester 0 waits
        req_valid = 3'b011;
        a[0] = 5'd7; d[0] = 32'h0000_0055;
        a[1] = 5'd8; d[1] = 32'h0000_0066;
        cycle();
        req_valid = 3'b001;
        cycle();
        chk("bp_waddr", 32'(rf_waddr), 32'(7));
        chk("bp_wdata", rf_wdata, 32'h0000_0055);
        req_valid = 3'b000;
        cycle();

        // Register 0 write and reservation are both dropped
        req_valid = 3'b100; a[2] = 5'd0; d[2] = 32'hFFFF_FFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        cycle();
        rsv_valid = 1'b0;
        req_valid = 3'b000;
        cycle();
        chk("r0_pending", pending, 32'(0));

        // Round-robin with all three valid; ptr is 0 after the r0 grant
        a[0] = 5'd1; d[0] = 32'h0000_000A;
        a[1] = 5'd2; d[1] = 32'h0000_000B;
        a[2] = 5'd3; d[2] = 32'h0000_000C;
        req_valid = 3'b111;
        repeat (6) cycle();
        req_valid = 3'b000;
        cycle();

        // Scoreboard: reserve r5, write it, clear after commit
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        cycle();
        rsv_valid = 1'b0;
        chk("pend5_set", 32'(pending[5]), 32'(1));
        req_valid = 3'b010; a[1] = 5'd5; d[1] = 32'h1234_5678;
        cycle();
        req_valid = 3'b000;
        cycle();
        chk("pend5_clr", 32'(pending[5]), 32'(0));

        // Same again, with a fresh reservation on the commit edge
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        cycle();
        rsv_valid = 1'b0;
        req_valid = 3'b010; d[1] = 32'h8765_4321;
        cycle();
        req_valid = 3'b000;
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        cycle();
        rsv_valid = 1'b0;
        chk("pend5_setwins", 32'(pending[5]), 32'(1));

        // Idle: outputs hold, pointer unchanged (next 111 grant shows it)
        req_valid = 3'b000;
        repeat (4) cycle();
        a[0] = 5'd10; d[0] = 32'h0000_1010;
        a[1] = 5'd11; d[1] = 32'h0000_1111;
        a[2] = 5'd12; d[2] = 32'h0000_1212;
        req_valid = 3'b111;
        cycle();
        req_valid = 3'b000;
        cycle();

        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Shares the single write port of the 32 x 32-bit register file among three writeback requesters: 0 = ALU, 1 = load unit, 2 = multiply/divide unit. Grants one requester per cycle, round-robin, and drives a registered write-port triple (`rf_we`, `rf_waddr`, `rf_wdata`). Keeps a per-register pending scoreboard so the issue stage can stall on read-after-write hazards. Sits between the execute/memory units and the register file write port.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width (32 registers)
- `NREQ`, 3, number of requesters (fixed at 3; other values unsupported)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester write request
- `req_ready`  out  NREQ  per-requester grant (combinational)
- `req_addr`  in  NREQ*ADDR_W  destination index; requester i at bits [i*ADDR_W +: ADDR_W]
- `req_data`  in  NREQ*DATA_W  write data; requester i at bits [i*DATA_W +: DATA_W]
- `rsv_valid`  in  1  issue stage reserves a destination register
- `rsv_addr`  in  ADDR_W  register being reserved
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  ADDR_W  register-file write index (registered)
- `rf_wdata`  out  DATA_W  register-file write data (registered)
- `pending`  out  32  bit r = 1: a write to register r is outstanding

## Operation
- Handshake per requester:
  - Transfer occurs when `req_valid[i] & req_ready[i]`.
  - Once raised, `req_valid` and its addr/data stay stable until the transfer.
  - `req_ready` is a pure function of `req_valid` and the priority pointer `ptr`.
- Arbitration:
  - At most one `req_ready` bit is high per cycle.
  - Winner is the first valid requester scanning `ptr`, `ptr+1`, `ptr+2` (mod 3).
  - No valid requesters: `req_ready` = 0.
- Pointer:
  - On a transfer by requester g, `ptr` <= (g+1) mod 3.
  - No transfer: `ptr` holds.
- Write port:
  - On a transfer, next cycle drives `rf_we`=1 with the granted addr/data.
  - Otherwise `rf_we`=0; `rf_waddr`/`rf_wdata` hold their last values.
- Register 0:
  - A transfer to addr 0 is accepted (ready asserted, pointer advances).
  - `rf_we` stays 0 for it.
  - `rsv_addr`=0 is ignored; `pending[0]` is always 0.
- Scoreboard:
  - `rsv_valid` sets `pending[rsv_addr]` at the clock edge.
  - A committed write (the edge ending an `rf_we`=1 cycle) clears `pending[rf_waddr]`.
  - Set and clear of the same bit on the same edge: set wins (newer producer).
  - Different bits update independently.
- Reset: `ptr`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `pending`=0, immediately on `rst` rise, regardless of clock.
  - An in-flight registered write is dropped.
  - Requesters re-present after reset.
  - `req_ready` is 0 while `rst` is high.

## Timing
- Latency:
  - Handshake at edge k gives `rf_we`=1 during cycle k to k+1.
  - The register file commits at edge k+1.
  - `pending` clears at edge k+1.
- Throughput: one write per cycle sustained. Three continuously valid requesters are served 0,1,2,0,… (per `ptr`). Each requester waits at most 2 cycles.
- `pending` is a registered output, visible the cycle after the edge that changes it.
- No combinational path from `req_*` to `rf_*` or `pending`.

## Test plan
- Reset: assert `rst` mid-cycle with `rf_we`=1 and `pending`=0x0000_0010.
  - Outputs go to 0 immediately, with no clock edge.
  - After release, `req_valid`=3'b001 gives `req_ready`=3'b001.
- Round-robin: hold `req_valid`=3'b111 for 6 cycles, addrs 1/2/3, data 0xA/0xB/0xC.
  - `rf_waddr` sequence is 1,2,3,1,2,3 with matching data; `rf_we`=1 every cycle.
- Backpressure: `req_valid`=3'b011 with `ptr`=1.
  - Requester 1 is granted first.
  - Requester 0 holds addr 7 / data 0x55 one extra cycle.
  - Then `rf_waddr`=7, `rf_wdata`=0x55.
- Register 0: requester 2 writes addr 0, data 0xFFFF_FFFF.
  - `req_ready[2]`=1, `rf_we` stays 0, `ptr` becomes 0.
  - `rsv_addr`=0 leaves `pending`=0.
- Scoreboard:
  - Reserve r5 → `pending[5]`=1.
  - Requester 1 writes r5 → `pending[5]`=0 the cycle after `rf_we`.
  - Repeat with `rsv_valid`/`rsv_addr`=5 on the commit edge → `pending[5]` remains 1.
- Idle: `req_valid`=0 for 4 cycles.
  - `rf_we`=0, `ptr` unchanged.
  - `rf_waddr`/`rf_wdata` hold their previous values.
